// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a request/ready handshake with a
// byte address out and a 32-bit instruction word back.
interface if_fetch_stage_if #(
  parameter int PC_W = 8
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic [31:0]     rdata;
  logic            ready;

  modport master (output req, addr, input rdata, ready);
  modport slave  (input req, addr, output rdata, ready);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage with the IF/ID register; one-deep pending buffer absorbs a word
// that lands while decode is stalled. Optional IF_MISALIGN_CHECK_EN adds misalign_out.
module if_fetch_stage #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  if_fetch_stage_if.master   imem,
  output logic [PC_W-1:0]    pc_out,
  output logic [31:0]        instruction_out,
  output logic               valid_out,
  output logic [4:0]         IF_ID_rs1,
  output logic [4:0]         IF_ID_rs2,
  output logic [4:0]         IF_ID_rd
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic               misalign_out
`endif
);

  typedef enum logic {FETCH, HOLD} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt;
  logic            req_q, req_d;
  ifid_t           out_q, out_d, pend_q, pend_d;
  logic            vld_q, vld_d;
  logic            mis_q, mis_d;
  logic            xfer;

  assign xfer = req_q & imem.ready;

`ifdef IF_MISALIGN_CHECK_EN
  assign tgt   = {branch_target[PC_W-1:2], 2'b00};
  assign mis_d = mis_q | (flush & (|branch_target[1:0]));
  assign misalign_out = mis_q;
`else
  assign tgt   = branch_target;
  assign mis_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    out_d   = out_q;
    vld_d   = vld_q;
    pend_d  = pend_q;
    if (flush) begin
      // A word completing this cycle belongs to the wrong path and is dropped.
      state_d = FETCH;
      req_d   = 1'b1;
      pc_d    = tgt;
      out_d   = '{pc: '0, instr: NOP_INSTR};
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          req_d = 1'b1;
          if (xfer) begin
            pc_d = pc_q + PC_W'(4);
            if (stall) begin
              pend_d  = '{pc: pc_q, instr: imem.rdata};
              state_d = HOLD;
              req_d   = 1'b0;
            end else begin
              out_d = '{pc: pc_q, instr: imem.rdata};
              vld_d = 1'b1;
            end
          end else if (!stall) begin
            out_d.instr = NOP_INSTR;
            vld_d       = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_d   = pend_q;
            vld_d   = 1'b1;
            state_d = FETCH;
            req_d   = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      out_q     <= '{pc: '0, instr: NOP_INSTR};
      vld_q     <= 1'b0;
      pend_q    <= '0;
      mis_q     <= 1'b0;
      IF_ID_rs1 <= '0;
      IF_ID_rs2 <= '0;
      IF_ID_rd  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      pend_q    <= pend_d;
      mis_q     <= mis_d;
      IF_ID_rs1 <= out_d.instr[19:15];
      IF_ID_rs2 <= out_d.instr[24:20];
      IF_ID_rd  <= out_d.instr[11:7];
    end
  end

  assign imem.req        = req_q;
  assign imem.addr       = pc_q;
  assign pc_out          = out_q.pc;
  assign instruction_out = out_q.instr;
  assign valid_out       = vld_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: a transaction-level model predicts the
// post-edge view each cycle, a monitor pops and compares after every rising edge.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [7:0]  pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic [4:0]  rs1, rs2, rd;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign_out;
`endif

  if_fetch_stage_if #(.PC_W(8)) imem ();

  if_fetch_stage #(.PC_W(8), .RESET_PC(8'h00), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem(imem.master),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_rd(rd)
`ifdef IF_MISALIGN_CHECK_EN
    , .misalign_out(misalign_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
    logic        v;
    logic        req;
    logic [7:0]  addr;
    logic        mis;
  } exp_t;
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } word_t;

  exp_t  sb[$];
  word_t pend[$];

  int checks = 0, errors = 0;

  // Model: fetch address, whether a request is outstanding, visible IF/ID word.
  logic [7:0]  m_pc;
  logic        m_req, m_v, m_mis;
  logic [7:0]  m_opc;
  logic [31:0] m_ins;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_req = 1'b0; m_v = 1'b0; m_mis = 1'b0;
    m_opc = 8'h00; m_ins = NOP;
    pend.delete();
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {8'hC0, a, 8'h5A, a};
  endfunction

  // One clock: drive inputs at the falling edge and predict the next rising edge.
  task automatic step(input logic s, input logic f, input logic [7:0] t,
                      input logic r, input logic [31:0] w);
    word_t p;
    logic  got;
    @(negedge clk);
    stall = s; flush = f; branch_target = t; imem.ready = r; imem.rdata = w;
    got = m_req && r;
    if (f) begin
`ifdef IF_MISALIGN_CHECK_EN
      if (t[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = t & 8'hFC;
`else
      m_pc = t;
`endif
      pend.delete();
      m_opc = 8'h00; m_ins = NOP; m_v = 1'b0;
    end else if (pend.size() > 0) begin
      if (!s) begin
        p = pend.pop_front();
        m_opc = p.pc; m_ins = p.ins; m_v = 1'b1;
      end
    end else if (got) begin
      if (s) pend.push_back('{pc: m_pc, ins: w});
      else begin m_opc = m_pc; m_ins = w; m_v = 1'b1; end
      m_pc = m_pc + 8'd4;
    end else if (!s) begin
      m_ins = NOP; m_v = 1'b0;
    end
    m_req = (pend.size() == 0);
    sb.push_back('{pc: m_opc, ins: m_ins, v: m_v, req: m_req, addr: m_pc, mis: m_mis});
  endtask

  task automatic fetch_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, word_at(m_pc));
  endtask

  task automatic check_reset_view();
    chk("rst_pc_out", {24'h0, pc_out}, 32'h0);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_req", {31'h0, imem.req}, 32'h0);
    chk("rst_addr", {24'h0, imem.addr}, 32'h0);
    chk("rst_fields", {17'h0, rs1, rs2, rd}, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
    chk("rst_misalign", {31'h0, misalign_out}, 32'h0);
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_out", {24'h0, pc_out}, {24'h0, e.pc});
        chk("instruction_out", instruction_out, e.ins);
        chk("valid_out", {31'h0, valid_out}, {31'h0, e.v});
        chk("fields", {17'h0, rs1, rs2, rd},
            {17'h0, e.ins[19:15], e.ins[24:20], e.ins[11:7]});
        chk("imem_req", {31'h0, imem.req}, {31'h0, e.req});
        chk("imem_addr", {24'h0, imem.addr}, {24'h0, e.addr});
`ifdef IF_MISALIGN_CHECK_EN
        chk("misalign_out", {31'h0, misalign_out}, {31'h0, e.mis});
`endif
      end
    end
  end

  initial begin : driver
    imem.ready = 1'b0; imem.rdata = '0;
    model_reset();
    #23;
    check_reset_view();
    @(posedge clk); #3; rst_n = 1'b1;

    // Streaming fetch from the reset PC.
    fetch_n(4);

    // Word lands under stall, held for three cycles, then released.
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'h00A2_8293);
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #3;
    chk("addi_rs1", {27'h0, rs1}, 32'd5);
    chk("addi_rs2", {27'h0, rs2}, 32'd10);
    chk("addi_rd", {27'h0, rd}, 32'd5);
    fetch_n(2);

    // Memory not ready: bubbles with a stable address.
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h1111_1111);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h2222_2222);
    fetch_n(2);

    // Flush beats stall and discards the completing word.
    step(1'b1, 1'b1, 8'h40, 1'b1, 32'hBAD0_BAD0);
    fetch_n(2);

    // PC wrap-around.
    step(1'b0, 1'b1, 8'hFC, 1'b0, 32'h0);
    fetch_n(3);

    // Reset while holding a pending word.
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'h0055_0533);
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_view();
    stall = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    fetch_n(3);

`ifdef IF_MISALIGN_CHECK_EN
    step(1'b0, 1'b1, 8'h42, 1'b1, 32'h0);
    fetch_n(2);
`endif

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           8'($urandom), $urandom_range(0, 9) < 7, $urandom);
    end

    @(posedge clk); #3;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
